// File: rtl/mem_access_unit.sv
// mem_access_unit: memory stage of the pipeline. Takes one execute-stage
// result at a time, checks alignment, issues a single bus request for aligned
// loads/stores, waits for the response with a timeout, and presents the
// result with exception flags {timeout, access_fault, store_misalign, load_misalign}.

`ifndef XLEN
`define XLEN 64
`endif
`ifndef REG_ADDRWIDTH
`define REG_ADDRWIDTH 5
`endif
`ifndef MEMOP_LEN
`define MEMOP_LEN 4
`endif

module mem_access_unit #(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      in_valid_i,
    output logic                      in_ready_o,
    input  logic [`XLEN-1:0]          pc_i,
    input  logic [`REG_ADDRWIDTH-1:0] rd_idx_i,
    input  logic [`MEMOP_LEN-1:0]     mem_op_i,
    input  logic [`XLEN-1:0]          exc_alu_data_i,
    input  logic [`XLEN-1:0]          rs2_data_i,
    output logic                      mem_req_valid_o,
    input  logic                      mem_req_ready_i,
    output logic [`XLEN-1:0]          mem_addr_o,
    output logic                      mem_wen_o,
    output logic [`XLEN-1:0]          mem_wdata_o,
    output logic [7:0]                mem_wstrb_o,
    input  logic                      mem_rsp_valid_i,
    input  logic [`XLEN-1:0]          mem_rdata_i,
    input  logic                      mem_rsp_err_i,
    output logic                      out_valid_o,
    input  logic                      out_ready_i,
    output logic [`XLEN-1:0]          out_pc_o,
    output logic [`REG_ADDRWIDTH-1:0] out_rd_idx_o,
    output logic [`XLEN-1:0]          out_data_o,
    output logic [3:0]                out_exc_o,
    output logic                      mem_stall_o
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_REQ  = 2'd1;
    localparam logic [1:0] ST_WAIT = 2'd2;
    localparam logic [1:0] ST_DONE = 2'd3;

    // Memory operation encoding shared with the decode stage.
    localparam logic [`MEMOP_LEN-1:0] OP_LB  = 4'd1;
    localparam logic [`MEMOP_LEN-1:0] OP_LH  = 4'd2;
    localparam logic [`MEMOP_LEN-1:0] OP_LW  = 4'd3;
    localparam logic [`MEMOP_LEN-1:0] OP_LD  = 4'd4;
    localparam logic [`MEMOP_LEN-1:0] OP_LBU = 4'd5;
    localparam logic [`MEMOP_LEN-1:0] OP_LHU = 4'd6;
    localparam logic [`MEMOP_LEN-1:0] OP_LWU = 4'd7;
    localparam logic [`MEMOP_LEN-1:0] OP_SB  = 4'd8;
    localparam logic [`MEMOP_LEN-1:0] OP_SD  = 4'd11;

    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    function automatic logic is_load(input logic [`MEMOP_LEN-1:0] op);
        return (op >= OP_LB) && (op <= OP_LWU);
    endfunction

    function automatic logic is_store(input logic [`MEMOP_LEN-1:0] op);
        return (op >= OP_SB) && (op <= OP_SD);
    endfunction

    // Access size as log2(bytes): 0=B, 1=H, 2=W, 3=D.
    function automatic logic [1:0] op_size(input logic [`MEMOP_LEN-1:0] op);
        logic [1:0] sz;
        case (op)
            4'd1, 4'd5, 4'd8:  sz = 2'd0;
            4'd2, 4'd6, 4'd9:  sz = 2'd1;
            4'd3, 4'd7, 4'd10: sz = 2'd2;
            4'd4, 4'd11:       sz = 2'd3;
            default:           sz = 2'd0;
        endcase
        return sz;
    endfunction

    function automatic logic misaligned(input logic [1:0] sz, input logic [2:0] off);
        logic m;
        case (sz)
            2'd1:    m = off[0];
            2'd2:    m = (off[1:0] != 2'b00);
            2'd3:    m = (off != 3'b000);
            default: m = 1'b0;
        endcase
        return m;
    endfunction

    // Pick the addressed lane out of the 64-bit read beat and extend it.
    function automatic logic [`XLEN-1:0] load_extract(input logic [`MEMOP_LEN-1:0] op,
                                                      input logic [2:0] off,
                                                      input logic [`XLEN-1:0] rdata);
        logic [`XLEN-1:0] sh;
        logic [`XLEN-1:0] res;
        sh = rdata >> {off, 3'b000};
        case (op)
            OP_LB:   res = {{56{sh[7]}}, sh[7:0]};
            OP_LH:   res = {{48{sh[15]}}, sh[15:0]};
            OP_LW:   res = {{32{sh[31]}}, sh[31:0]};
            OP_LBU:  res = {56'd0, sh[7:0]};
            OP_LHU:  res = {48'd0, sh[15:0]};
            OP_LWU:  res = {32'd0, sh[31:0]};
            OP_LD:   res = sh;
            default: res = 64'd0;
        endcase
        return res;
    endfunction

    logic [1:0]                state_r, state_nxt_s;
    logic [`XLEN-1:0]          pc_r, addr_r, wdata_r, data_r;
    logic [`REG_ADDRWIDTH-1:0] rd_r;
    logic [`MEMOP_LEN-1:0]     op_r;
    logic [3:0]                exc_r;
    logic [CNT_W-1:0]          cnt_r;
    logic                      accept_s;
    logic [1:0]                accept_state_s;
    logic [3:0]                accept_exc_s;
    logic [7:0]                strb_s;
    logic [`XLEN-1:0]          wrep_s;

    assign accept_s = in_valid_i & in_ready_o;

    // Classify the incoming operation: pass-through, misaligned, or bus access.
    always_comb begin
        accept_state_s = ST_DONE;
        accept_exc_s   = 4'b0000;
        if (!(is_load(mem_op_i) || is_store(mem_op_i))) begin
            accept_state_s = ST_DONE;
        end else if (misaligned(op_size(mem_op_i), exc_alu_data_i[2:0])) begin
            accept_state_s = ST_DONE;
            accept_exc_s   = is_store(mem_op_i) ? 4'b0010 : 4'b0001;
        end else begin
            accept_state_s = ST_REQ;
        end
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state logic.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (accept_s) state_nxt_s = accept_state_s;
                else          state_nxt_s = ST_IDLE;
            end
            ST_REQ: begin
                if (mem_req_ready_i) state_nxt_s = ST_WAIT;
                else                 state_nxt_s = ST_REQ;
            end
            ST_WAIT: begin
                if (mem_rsp_valid_i)        state_nxt_s = ST_DONE;
                else if (cnt_r == CNT_LAST) state_nxt_s = ST_DONE;
                else                        state_nxt_s = ST_WAIT;
            end
            ST_DONE: begin
                if (!out_ready_i)  state_nxt_s = ST_DONE;
                else if (accept_s) state_nxt_s = accept_state_s;
                else               state_nxt_s = ST_IDLE;
            end
            default: state_nxt_s = ST_IDLE;
        endcase
    end

    // Handshake and stall outputs decoded from the current state.
    always_comb begin
        in_ready_o      = 1'b0;
        mem_req_valid_o = 1'b0;
        out_valid_o     = 1'b0;
        mem_stall_o     = 1'b0;
        case (state_r)
            ST_IDLE: in_ready_o = 1'b1;
            ST_REQ: begin
                mem_req_valid_o = 1'b1;
                mem_stall_o     = 1'b1;
            end
            ST_WAIT: mem_stall_o = 1'b1;
            ST_DONE: begin
                out_valid_o = 1'b1;
                in_ready_o  = out_ready_i;
                mem_stall_o = ~out_ready_i;
            end
            default: in_ready_o = 1'b0;
        endcase
    end

    // Capture the operation on acceptance; update result, flags and timeout counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_r    <= 64'd0;
            rd_r    <= 5'd0;
            op_r    <= 4'd0;
            addr_r  <= 64'd0;
            wdata_r <= 64'd0;
            data_r  <= 64'd0;
            exc_r   <= 4'b0000;
            cnt_r   <= '0;
        end else if (accept_s) begin
            pc_r    <= pc_i;
            rd_r    <= rd_idx_i;
            op_r    <= mem_op_i;
            addr_r  <= exc_alu_data_i;
            wdata_r <= rs2_data_i;
            exc_r   <= accept_exc_s;
            data_r  <= (is_load(mem_op_i) || is_store(mem_op_i)) ? 64'd0 : exc_alu_data_i;
        end else begin
            case (state_r)
                ST_REQ: begin
                    if (mem_req_ready_i) cnt_r <= '0;
                    else                 cnt_r <= cnt_r;
                end
                ST_WAIT: begin
                    if (mem_rsp_valid_i) begin
                        exc_r  <= {1'b0, mem_rsp_err_i, 2'b00};
                        data_r <= is_store(op_r) ? 64'd0 : load_extract(op_r, addr_r[2:0], mem_rdata_i);
                    end else if (cnt_r == CNT_LAST) begin
                        exc_r  <= 4'b1000;
                        data_r <= 64'd0;
                        cnt_r  <= cnt_r + CNT_W'(1);
                    end else begin
                        cnt_r <= cnt_r + CNT_W'(1);
                    end
                end
                default: cnt_r <= cnt_r;
            endcase
        end
    end

    // Byte strobes and lane-replicated store data for the current access.
    always_comb begin
        strb_s = 8'h00;
        wrep_s = wdata_r;
        case (op_size(op_r))
            2'd0: begin strb_s = 8'h01; wrep_s = {8{wdata_r[7:0]}};  end
            2'd1: begin strb_s = 8'h03; wrep_s = {4{wdata_r[15:0]}}; end
            2'd2: begin strb_s = 8'h0F; wrep_s = {2{wdata_r[31:0]}}; end
            2'd3: begin strb_s = 8'hFF; wrep_s = wdata_r;            end
            default: begin strb_s = 8'h00; wrep_s = wdata_r;        end
        endcase
        if (is_store(op_r)) strb_s = strb_s << addr_r[2:0];
        else                strb_s = 8'h00;
    end

    assign mem_addr_o   = {addr_r[63:3], 3'b000};
    assign mem_wen_o    = is_store(op_r);
    assign mem_wdata_o  = wrep_s;
    assign mem_wstrb_o  = strb_s;
    assign out_pc_o     = pc_r;
    assign out_rd_idx_o = rd_r;
    assign out_data_o   = data_r;
    assign out_exc_o    = exc_r;

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed self-checking bench for mem_access_unit (TIMEOUT_CYCLES = 4).

`ifndef XLEN
`define XLEN 64
`endif
`ifndef REG_ADDRWIDTH
`define REG_ADDRWIDTH 5
`endif
`ifndef MEMOP_LEN
`define MEMOP_LEN 4
`endif

module tb_mem_access_unit;

    localparam logic [3:0] OP_NONE = 4'd0;
    localparam logic [3:0] OP_LB   = 4'd1;
    localparam logic [3:0] OP_LW   = 4'd3;
    localparam logic [3:0] OP_LD   = 4'd4;
    localparam logic [3:0] OP_LBU  = 4'd5;
    localparam logic [3:0] OP_LWU  = 4'd7;
    localparam logic [3:0] OP_SH   = 4'd9;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid_i, in_ready_o;
    logic [63:0] pc_i, exc_alu_data_i, rs2_data_i;
    logic [4:0]  rd_idx_i;
    logic [3:0]  mem_op_i;
    logic        mem_req_valid_o, mem_req_ready_i, mem_wen_o;
    logic [63:0] mem_addr_o, mem_wdata_o;
    logic [7:0]  mem_wstrb_o;
    logic        mem_rsp_valid_i, mem_rsp_err_i;
    logic [63:0] mem_rdata_i;
    logic        out_valid_o, out_ready_i;
    logic [63:0] out_pc_o, out_data_o;
    logic [4:0]  out_rd_idx_o;
    logic [3:0]  out_exc_o;
    logic        mem_stall_o;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    mem_access_unit #(.TIMEOUT_CYCLES(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid_i(in_valid_i), .in_ready_o(in_ready_o),
        .pc_i(pc_i), .rd_idx_i(rd_idx_i), .mem_op_i(mem_op_i),
        .exc_alu_data_i(exc_alu_data_i), .rs2_data_i(rs2_data_i),
        .mem_req_valid_o(mem_req_valid_o), .mem_req_ready_i(mem_req_ready_i),
        .mem_addr_o(mem_addr_o), .mem_wen_o(mem_wen_o),
        .mem_wdata_o(mem_wdata_o), .mem_wstrb_o(mem_wstrb_o),
        .mem_rsp_valid_i(mem_rsp_valid_i), .mem_rdata_i(mem_rdata_i),
        .mem_rsp_err_i(mem_rsp_err_i),
        .out_valid_o(out_valid_o), .out_ready_i(out_ready_i),
        .out_pc_o(out_pc_o), .out_rd_idx_o(out_rd_idx_o),
        .out_data_o(out_data_o), .out_exc_o(out_exc_o),
        .mem_stall_o(mem_stall_o)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic drive_in(input logic [3:0] op, input logic [63:0] addr,
                            input logic [63:0] rs2, input logic [63:0] pc, input logic [4:0] rd);
        in_valid_i     = 1'b1;
        mem_op_i       = op;
        exc_alu_data_i = addr;
        rs2_data_i     = rs2;
        pc_i           = pc;
        rd_idx_i       = rd;
    endtask

    initial begin
        rst_n = 1'b0; in_valid_i = 1'b0; pc_i = 64'd0; rd_idx_i = 5'd0;
        mem_op_i = 4'd0; exc_alu_data_i = 64'd0; rs2_data_i = 64'd0;
        mem_req_ready_i = 1'b0; mem_rsp_valid_i = 1'b0; mem_rdata_i = 64'd0;
        mem_rsp_err_i = 1'b0; out_ready_i = 1'b0;
        #3;
        chk("rst_out_valid", {63'd0, out_valid_o}, 64'd0);
        chk("rst_req_valid", {63'd0, mem_req_valid_o}, 64'd0);
        chk("rst_stall", {63'd0, mem_stall_o}, 64'd0);
        chk("rst_exc", {60'd0, out_exc_o}, 64'd0);
        chk("rst_data", out_data_o, 64'd0);
        #4 rst_n = 1'b1;
        #1;
        chk("rst_in_ready", {63'd0, in_ready_o}, 64'd1);

        // LB at 0x8000_0003, byte 3 = 0x80 -> sign-extended
        tick();
        drive_in(OP_LB, 64'h8000_0003, 64'd0, 64'h100, 5'd5);
        tick();
        in_valid_i = 1'b0;
        mem_req_ready_i = 1'b1;
        mem_rsp_valid_i = 1'b1; mem_rdata_i = 64'hFFFF_FFFF_FFFF_FFFF;
        #1;
        chk("lb_req_valid", {63'd0, mem_req_valid_o}, 64'd1);
        chk("lb_addr", mem_addr_o, 64'h8000_0000);
        chk("lb_wstrb", {56'd0, mem_wstrb_o}, 64'h00);
        chk("lb_stall_req", {63'd0, mem_stall_o}, 64'd1);
        tick();
        mem_req_ready_i = 1'b0;
        mem_rdata_i = 64'h0000_0000_8000_0000;
        #1;
        chk("lb_same_cycle_rsp_ignored", {63'd0, out_valid_o}, 64'd0);
        chk("lb_stall_wait", {63'd0, mem_stall_o}, 64'd1);
        tick();
        mem_rsp_valid_i = 1'b0;
        #1;
        chk("lb_out_valid", {63'd0, out_valid_o}, 64'd1);
        chk("lb_data", out_data_o, 64'hFFFF_FFFF_FFFF_FF80);
        chk("lb_exc", {60'd0, out_exc_o}, 64'd0);
        chk("lb_pc", out_pc_o, 64'h100);
        chk("lb_rd", {59'd0, out_rd_idx_o}, 64'd5);
        out_ready_i = 1'b1;
        tick();
        out_ready_i = 1'b0;
        #1;
        chk("lb_back_idle", {63'd0, out_valid_o}, 64'd0);

        // SH at ...6 with request stalled for 5 cycles
        drive_in(OP_SH, 64'h0000_1006, 64'h1234, 64'h104, 5'd0);
        tick();
        in_valid_i = 1'b0;
        for (int i = 0; i < 5; i++) begin
            #1;
            chk("sh_hold_valid", {63'd0, mem_req_valid_o}, 64'd1);
            chk("sh_hold_addr", mem_addr_o, 64'h1000);
            chk("sh_hold_wstrb", {56'd0, mem_wstrb_o}, 64'hC0);
            chk("sh_hold_wdata", mem_wdata_o, 64'h1234_1234_1234_1234);
            chk("sh_hold_wen", {63'd0, mem_wen_o}, 64'd1);
            chk("sh_hold_stall", {63'd0, mem_stall_o}, 64'd1);
            tick();
        end
        mem_req_ready_i = 1'b1;
        tick();
        mem_req_ready_i = 1'b0;
        mem_rsp_valid_i = 1'b1; mem_rdata_i = 64'h1111_2222_3333_4444;
        tick();
        mem_rsp_valid_i = 1'b0;
        #1;
        chk("sh_out_valid", {63'd0, out_valid_o}, 64'd1);
        chk("sh_data_zero", out_data_o, 64'd0);
        chk("sh_exc", {60'd0, out_exc_o}, 64'd0);
        tick();
        chk("sh_done_hold_valid", {63'd0, out_valid_o}, 64'd1);
        chk("sh_done_hold_pc", out_pc_o, 64'h104);
        chk("sh_done_stall", {63'd0, mem_stall_o}, 64'd1);
        out_ready_i = 1'b1;
        #1;
        chk("sh_done_in_ready", {63'd0, in_ready_o}, 64'd1);
        chk("sh_done_nostall", {63'd0, mem_stall_o}, 64'd0);
        tick();
        out_ready_i = 1'b0;

        // LW misaligned at ...2 -> load_misalign, no bus request
        drive_in(OP_LW, 64'h0000_2002, 64'd0, 64'h108, 5'd3);
        tick();
        in_valid_i = 1'b0;
        #1;
        chk("lw_mis_no_req", {63'd0, mem_req_valid_o}, 64'd0);
        chk("lw_mis_valid", {63'd0, out_valid_o}, 64'd1);
        chk("lw_mis_exc", {60'd0, out_exc_o}, 64'b0001);
        out_ready_i = 1'b1;
        tick();
        out_ready_i = 1'b0;

        // LD with no response -> timeout after 4 WAIT cycles
        drive_in(OP_LD, 64'h0000_3000, 64'd0, 64'h10C, 5'd4);
        tick();
        in_valid_i = 1'b0;
        mem_req_ready_i = 1'b1;
        tick();
        mem_req_ready_i = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("to_still_wait", {63'd0, out_valid_o}, 64'd0);
            tick();
        end
        chk("to_still_wait_4", {63'd0, out_valid_o}, 64'd0);
        tick();
        chk("to_done", {63'd0, out_valid_o}, 64'd1);
        chk("to_exc", {60'd0, out_exc_o}, 64'b1000);
        mem_rsp_valid_i = 1'b1; mem_rdata_i = 64'h5555_5555_5555_5555; mem_rsp_err_i = 1'b1;
        tick();
        mem_rsp_valid_i = 1'b0; mem_rsp_err_i = 1'b0;
        chk("to_stray_exc", {60'd0, out_exc_o}, 64'b1000);
        chk("to_stray_data", out_data_o, 64'd0);
        out_ready_i = 1'b1;
        tick();
        out_ready_i = 1'b0;

        // LWU at ...4 with bus error -> access_fault, zero-extended upper word
        drive_in(OP_LWU, 64'h0000_5004, 64'd0, 64'h110, 5'd6);
        tick();
        in_valid_i = 1'b0;
        mem_req_ready_i = 1'b1;
        tick();
        mem_req_ready_i = 1'b0;
        mem_rsp_valid_i = 1'b1; mem_rdata_i = 64'hDEAD_BEEF_0BAD_F00D; mem_rsp_err_i = 1'b1;
        tick();
        mem_rsp_valid_i = 1'b0; mem_rsp_err_i = 1'b0;
        #1;
        chk("lwu_data", out_data_o, 64'h0000_0000_DEAD_BEEF);
        chk("lwu_exc", {60'd0, out_exc_o}, 64'b0100);
        out_ready_i = 1'b1;
        tick();

        // Two back-to-back pass-through results
        drive_in(OP_NONE, 64'hAAAA, 64'd0, 64'h10, 5'd1);
        tick();
        drive_in(OP_NONE, 64'hBBBB, 64'd0, 64'h14, 5'd2);
        #1;
        chk("b2b1_valid", {63'd0, out_valid_o}, 64'd1);
        chk("b2b1_data", out_data_o, 64'hAAAA);
        chk("b2b1_pc", out_pc_o, 64'h10);
        chk("b2b1_in_ready", {63'd0, in_ready_o}, 64'd1);
        tick();
        in_valid_i = 1'b0;
        #1;
        chk("b2b2_valid", {63'd0, out_valid_o}, 64'd1);
        chk("b2b2_data", out_data_o, 64'hBBBB);
        chk("b2b2_rd", {59'd0, out_rd_idx_o}, 64'd2);
        tick();
        chk("b2b_idle", {63'd0, out_valid_o}, 64'd0);
        out_ready_i = 1'b0;

        // Reset pulsed in WAIT: abort, outputs zeroed, late response ignored
        drive_in(OP_LBU, 64'h0000_4001, 64'd0, 64'h200, 5'd7);
        tick();
        in_valid_i = 1'b0;
        mem_req_ready_i = 1'b1;
        tick();
        mem_req_ready_i = 1'b0;
        #1;
        chk("rw_in_wait_stall", {63'd0, mem_stall_o}, 64'd1);
        rst_n = 1'b0;
        #1;
        chk("rw_stall", {63'd0, mem_stall_o}, 64'd0);
        chk("rw_req_valid", {63'd0, mem_req_valid_o}, 64'd0);
        chk("rw_out_valid", {63'd0, out_valid_o}, 64'd0);
        chk("rw_pc", out_pc_o, 64'd0);
        chk("rw_addr", mem_addr_o, 64'd0);
        rst_n = 1'b1;
        mem_rsp_valid_i = 1'b1; mem_rdata_i = 64'hFF; mem_rsp_err_i = 1'b1;
        tick();
        mem_rsp_valid_i = 1'b0; mem_rsp_err_i = 1'b0;
        chk("rw_late_rsp_valid", {63'd0, out_valid_o}, 64'd0);
        chk("rw_late_rsp_exc", {60'd0, out_exc_o}, 64'd0);
        chk("rw_late_rsp_data", out_data_o, 64'd0);
        chk("rw_in_ready", {63'd0, in_ready_o}, 64'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/mem_access_unit.md
MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

Interface
REQ-001 The block SHALL have parameter TIMEOUT_CYCLES, default 255, the maximum number of cycles spent waiting for one bus response.
REQ-002 The block SHALL have port clk, input, 1 bit, the single clock.
REQ-003 The block SHALL have port rst_n, input, 1 bit, reset: asynchronous, active-low.
REQ-004 The block SHALL have port in_valid_i, input, 1 bit, an execute-stage result is present.
REQ-005 The block SHALL have port in_ready_o, output, 1 bit, the block accepts the execute-stage result.
REQ-006 The block SHALL have ports pc_i (`XLEN), rd_idx_i (`REG_ADDRWIDTH), mem_op_i (`MEMOP_LEN) and exc_alu_data_i (`XLEN, the address or ALU result), all inputs.
REQ-007 The block SHALL have port rs2_data_i, input, `XLEN, the store data.
REQ-008 The block SHALL have the bus request ports mem_req_valid_o (out, 1), mem_req_ready_i (in, 1), mem_addr_o (out, `XLEN), mem_wen_o (out, 1), mem_wdata_o (out, `XLEN) and mem_wstrb_o (out, 8).
REQ-009 The block SHALL have the bus response ports mem_rsp_valid_i (in, 1), mem_rdata_i (in, `XLEN) and mem_rsp_err_i (in, 1).
REQ-010 The block SHALL have the output ports out_valid_o (out, 1), out_ready_i (in, 1), out_pc_o (out, `XLEN), out_rd_idx_o (out, `REG_ADDRWIDTH) and out_data_o (out, `XLEN).
REQ-011 The block SHALL have port out_exc_o, output, 4 bits, exception flags: {timeout, access_fault, store_misalign, load_misalign}.
REQ-012 The block SHALL have port mem_stall_o, output, 1 bit, a stall request to pipeline control.

Function
REQ-013 The state machine SHALL have the states IDLE, REQ, WAIT and DONE; a transfer occurs when valid and ready are both 1 in the same cycle.
REQ-014 in_ready_o SHALL equal 1 only in IDLE, or in DONE in the same cycle that out_ready_i is 1.
REQ-015 On input acceptance, the block SHALL register pc, rd_idx, mem_op, address and store data.
REQ-016 An accepted MEMOP_NONE SHALL go to DONE with out_data_o equal to exc_alu_data_i, giving a latency of 1 cycle.
REQ-017 An accepted load or store SHALL check alignment: H requires addr[0]==0, W requires addr[1:0]==0, D requires addr[2:0]==0.
REQ-018 A misaligned access SHALL go directly to DONE with the matching misalign flag set, and the block SHALL NOT issue a bus request for it.
REQ-019 An aligned access SHALL go to REQ; in REQ, mem_req_valid_o SHALL be 1 and the request outputs SHALL stay stable until mem_req_ready_i is 1.
REQ-020 When mem_req_ready_i is 1 in REQ, the block SHALL move to WAIT and clear the timeout counter.
REQ-021 mem_addr_o SHALL be the address with bits [2:0] cleared.
REQ-022 mem_wstrb_o SHALL be 0x01, 0x03, 0x0F or 0xFF for B, H, W or D respectively, shifted left by addr[2:0]; it SHALL be 0x00 for loads.
REQ-023 mem_wdata_o SHALL be the store data replicated across lanes: a byte in all 8 lanes, a half in all 4 halves, a word in both words.
REQ-024 In WAIT, the block SHALL ignore mem_rsp_valid_i=0 and increment the counter each cycle.
REQ-025 When the counter reaches TIMEOUT_CYCLES in WAIT, the block SHALL go to DONE with the timeout flag set, and SHALL discard any later stray response until the next REQ.
REQ-026 When mem_rsp_valid_i is 1 in WAIT, the block SHALL go to DONE, set access_fault to mem_rsp_err_i, and compute the load result.
REQ-027 The load result SHALL be the field of mem_rdata_i selected by addr[2:0] and size, sign-extended for LB/LH/LW and zero-extended for LBU/LHU/LWU/LD.
REQ-028 A completed store SHALL produce out_data_o = 0.
REQ-029 A response arriving in the same cycle as the request handshake SHALL NOT be accepted; a response is valid only in WAIT.
REQ-030 In DONE, out_valid_o SHALL be 1 and all out_* outputs SHALL be held stable until out_ready_i is 1.
REQ-031 When out_ready_i and in_valid_i are both 1 in DONE, the block SHALL accept the next input in the same cycle (back-to-back); otherwise it SHALL return to IDLE.
REQ-032 mem_stall_o SHALL be 1 in REQ and in WAIT, and in DONE while out_ready_i is 0.
REQ-033 mem_stall_o SHALL be 0 in IDLE.

Reset
REQ-034 While rst_n is 0, asynchronously: the state SHALL be IDLE; the counter and all registered fields SHALL be 0; mem_req_valid_o, out_valid_o and mem_stall_o SHALL be 0; out_exc_o SHALL be 0; in_ready_o SHALL be 1 after release.
REQ-035 A reset asserted during REQ or WAIT SHALL abort the access with no further bus activity, and a response arriving after reset release SHALL be ignored.

Verification
REQ-036 The bench SHALL cover: LB, address 0x8000_0003, rdata 0x0000_0000_8000_0000 with byte 3 = 0x80 -> mem_addr_o 0x8000_0000, out_data_o 0xFFFF_FFFF_FFFF_FF80.
REQ-037 The bench SHALL cover: SH, address 0x...6, rs2 0x1234 -> mem_wstrb_o 0xC0, mem_wdata_o 0x1234123412341234, out_data_o 0.
REQ-038 The bench SHALL cover: LW, address 0x...2 -> no mem_req_valid_o, out_exc_o 0b0001 on the next cycle.
REQ-039 The bench SHALL cover: mem_req_ready_i held 0 for 5 cycles -> request outputs stable and mem_stall_o 1 throughout.
REQ-040 The bench SHALL cover: no response with TIMEOUT_CYCLES=4 -> DONE after 4 WAIT cycles, out_exc_o 0b1000.
REQ-041 The bench SHALL cover: two back-to-back MEMOP_NONE inputs with out_ready_i=1 -> one result per cycle in order, and rst_n pulsed in WAIT -> IDLE and outputs zeroed immediately.
